// File: rtl/slave_wr_packer.sv
// Purpose : packs received SPI-slave bytes into 16-bit SRAM input-FIFO write requests.
// Latency : a byte pushed into empty staging in IDLE raises slave_write one cycle later.
// Backpressure: 4-entry staging absorbs bytes while a request waits for slave_hint;
//           bytes arriving with staging full (and no pop that cycle) are dropped and flagged.
//
// Ports:
//   clk, rst_n          - clock; async-assert / sync-release active-low reset
//   byte_in, byte_valid - received byte and its single-cycle strobe (cannot be stalled)
//   pkt_end             - byte is the last of its packet
//   byte_ready          - staging buffer has a free entry
//   slave_write         - level write request, held until slave_hint
//   slave_data_to_sram  - word being written, stable while slave_write=1
//   slave_hint          - one-cycle completion pulse from the SRAM controller
//   fifo_i_full         - SRAM input FIFO full (status only, never drops the word)
//   words_written       - count of acknowledged words (wraps)
//   overflow_err        - sticky: a byte was dropped
//   stalled             - request pending while the SRAM input FIFO is full
//
// Optional build macro: SLAVE_PACK_TIMEOUT_EN
//   When defined, a lone high byte waiting in HALF with staging empty for
//   TIMEOUT_CYCLES consecutive cycles is flushed as {high, 8'h00}.

module slave_wr_packer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        pkt_end,
    output logic        byte_ready,
    output logic        slave_write,
    output logic [15:0] slave_data_to_sram,
    input  logic        slave_hint,
    input  logic        fifo_i_full,
    output logic [15:0] words_written,
    output logic        overflow_err,
    output logic        stalled
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        REQ  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate (async clear of the
    // chain propagates straight to rst_int_n), release is aligned to clk.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t      state_q;
    state_t      state_nxt;
    logic [7:0]  hi_q;
    logic [7:0]  hi_nxt;
    logic [15:0] data_q;
    logic [15:0] data_nxt;
    logic        write_q;
    logic [15:0] words_q;
    logic        ovf_q;
    logic        ack;
    logic        tmo_fire;

    localparam int STG_DEPTH = 4;

    logic [8:0]  stg_mem [STG_DEPTH];
    logic [1:0]  stg_wr_ptr;
    logic [1:0]  stg_rd_ptr;
    logic [2:0]  stg_cnt;
    logic        stg_empty;
    logic        stg_full;
    logic        stg_push;
    logic        stg_pop;
    logic        byte_drop;
    logic        ent_end;
    logic [7:0]  ent_byte;

    // ------------------------------------------------------------------
    // Staging FIFO: 4 x {pkt_end, byte}
    // ------------------------------------------------------------------
    assign stg_empty  = (stg_cnt == 3'd0);
    assign stg_full   = (stg_cnt == 3'd4);
    assign byte_ready = !stg_full;

    // The packer drains one entry per cycle whenever it is not holding a request.
    assign stg_pop   = (state_q != REQ) && !stg_empty;
    // A byte arriving at full still gets in if an entry leaves the same cycle.
    assign stg_push  = byte_valid && (!stg_full || stg_pop);
    assign byte_drop = byte_valid && !stg_push;

    assign {ent_end, ent_byte} = stg_mem[stg_rd_ptr];

    always_ff @(posedge clk) begin
        if (stg_push) begin
            stg_mem[stg_wr_ptr] <= {pkt_end, byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            stg_wr_ptr <= 2'd0;
            stg_rd_ptr <= 2'd0;
            stg_cnt    <= 3'd0;
        end else begin
            if (stg_push) begin
                stg_wr_ptr <= stg_wr_ptr + 2'd1;
            end
            if (stg_pop) begin
                stg_rd_ptr <= stg_rd_ptr + 2'd1;
            end
            case ({stg_push, stg_pop})
                2'b10:   stg_cnt <= stg_cnt + 3'd1;
                2'b01:   stg_cnt <= stg_cnt - 3'd1;
                default: stg_cnt <= stg_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Half-word flush timer
    // ------------------------------------------------------------------
`ifdef SLAVE_PACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive empty cycle spent in HALF.
    assign tmo_fire = (state_q == HALF) && stg_empty &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            tmo_cnt <= '0;
        end else if ((state_q == HALF) && stg_empty && (state_nxt == HALF)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            // Any pop or state change restarts the idle count.
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Packer FSM
    // ------------------------------------------------------------------
    assign ack = (state_q == REQ) && slave_hint;

    always_comb begin
        state_nxt = state_q;
        hi_nxt    = hi_q;
        data_nxt  = data_q;
        case (state_q)
            IDLE: begin
                if (!stg_empty) begin
                    if (ent_end) begin
                        data_nxt  = {ent_byte, 8'h00};
                        state_nxt = REQ;
                    end else begin
                        hi_nxt    = ent_byte;
                        state_nxt = HALF;
                    end
                end
            end
            HALF: begin
                // The second byte completes the word whatever its pkt_end says.
                if (!stg_empty) begin
                    data_nxt  = {hi_q, ent_byte};
                    state_nxt = REQ;
                end else if (tmo_fire) begin
                    data_nxt  = {hi_q, 8'h00};
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Dropping to IDLE for at least one cycle gives the SRAM
                // controller its re-arm gap before the next request.
                if (slave_hint) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            hi_q    <= 8'h00;
            data_q  <= 16'h0000;
            write_q <= 1'b0;
            words_q <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            hi_q    <= hi_nxt;
            data_q  <= data_nxt;
            write_q <= (state_nxt == REQ);
            if (ack) begin
                words_q <= words_q + 16'd1;
            end
            if (byte_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign slave_write        = write_q;
    assign slave_data_to_sram = data_q;
    assign words_written      = words_q;
    assign overflow_err       = ovf_q;
    // fifo_i_full only reports; the pending word is held regardless.
    assign stalled            = write_q && fifo_i_full;

endmodule

// File: tb/tb_slave_wr_packer.sv
module tb_slave_wr_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        pkt_end;
    logic        byte_ready;
    logic        slave_write;
    logic [15:0] slave_data_to_sram;
    logic        slave_hint;
    logic        fifo_i_full;
    logic [15:0] words_written;
    logic        overflow_err;
    logic        stalled;

    slave_wr_packer #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .byte_in            (byte_in),
        .byte_valid         (byte_valid),
        .pkt_end            (pkt_end),
        .byte_ready         (byte_ready),
        .slave_write        (slave_write),
        .slave_data_to_sram (slave_data_to_sram),
        .slave_hint         (slave_hint),
        .fifo_i_full        (fifo_i_full),
        .words_written      (words_written),
        .overflow_err       (overflow_err),
        .stalled            (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: words the accepted byte stream must produce, in order.
    logic [15:0] exp_q[$];
    logic        m_half;
    logic [7:0]  m_hi;
    logic        m_ovf;
    logic [15:0] m_ww;

    logic        chk_en;
    logic        prev_sw;
    logic        ack_pend;
    logic [15:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_half   = 1'b0;
        m_hi     = 8'h00;
        m_ovf    = 1'b0;
        m_ww     = 16'h0000;
        prev_sw  = 1'b0;
        ack_pend = 1'b0;
        held     = 16'h0000;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic e);
        if (m_half) begin
            exp_q.push_back({m_hi, b});
            m_half = 1'b0;
        end else if (e) begin
            exp_q.push_back({b, 8'h00});
        end else begin
            m_hi   = b;
            m_half = 1'b1;
        end
    endtask

    task automatic model_flush();
        if (m_half) begin
            exp_q.push_back({m_hi, 8'h00});
            m_half = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // acc: hand-computed expectation whether the staging buffer takes the byte.
    task automatic send(input logic [7:0] b, input logic e, input bit acc);
        byte_in    = b;
        pkt_end    = e;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        pkt_end    = 1'b0;
        byte_in    = 8'h00;
        if (acc) model_byte(b, e);
        else     m_ovf = 1'b1;
    endtask

    task automatic wait_req(input int limit, output int lat, output bit ok);
        lat = 0;
        while (!slave_write && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = slave_write;
    endtask

    task automatic ack(input int n);
        step(n);
        slave_hint = 1'b1;
        step(1);
        slave_hint = 1'b0;
    endtask

    // Per-cycle compare against the model and the handshake rules.
    always @(negedge clk) begin
        if (chk_en) begin
            if (ack_pend) begin
                chk("req_low_after_hint", slave_write, 1'b0);
                m_ww = m_ww + 16'd1;
            end
            chk("words_written", words_written, m_ww);
            chk("overflow_err", overflow_err, m_ovf);
            chk("stalled", stalled, slave_write && fifo_i_full);
            if (slave_write && !prev_sw) begin
                chk("req_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    chk("req_data", slave_data_to_sram, exp_q.pop_front());
                end
                held = slave_data_to_sram;
            end else if (slave_write && prev_sw) begin
                chk("data_hold", slave_data_to_sram, held);
            end
            ack_pend = slave_write && slave_hint;
            prev_sw  = slave_write;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] ov_b [6];

    initial begin
        int lat;
        bit ok;

        rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; pkt_end = 1'b0;
        slave_hint = 1'b0; fifo_i_full = 1'b1; chk_en = 1'b0;
        model_reset();
        step(2);

        // Reset values (fifo_i_full high to show stalled stays low)
        chk("rst_slave_write", slave_write, 1'b0);
        chk("rst_data", slave_data_to_sram, 16'h0000);
        chk("rst_byte_ready", byte_ready, 1'b1);
        chk("rst_words", words_written, 16'h0000);
        chk("rst_overflow", overflow_err, 1'b0);
        chk("rst_stalled", stalled, 1'b0);

        fifo_i_full = 1'b0;
        rst_n = 1'b1;
        step(3);
        chk_en = 1'b1;

        // Hint outside REQ is ignored
        slave_hint = 1'b1;
        step(1);
        slave_hint = 1'b0;
        step(2);
        chk("idle_hint_ignored", words_written, 16'h0000);

        // A1,B2 (pkt_end on B2), acknowledged four cycles after the request
        send(8'hA1, 1'b0, 1'b1);
        send(8'hB2, 1'b1, 1'b1);
        wait_req(10, lat, ok);
        chk("a1b2_req_seen", ok, 1'b1);
        chk("a1b2_latency_le3", lat <= 3, 1'b1);
        chk("a1b2_data", slave_data_to_sram, 16'hA1B2);
        ack(4);
        step(2);
        chk("a1b2_words", words_written, 16'd1);
        chk("a1b2_write_low", slave_write, 1'b0);

        // Lone 5C with pkt_end
        send(8'h5C, 1'b1, 1'b1);
        wait_req(10, lat, ok);
        chk("5c_req_seen", ok, 1'b1);
        chk("5c_latency_le3", lat <= 3, 1'b1);
        chk("5c_data", slave_data_to_sram, 16'h5C00);
        ack(1);
        step(2);
        chk("5c_words", words_written, 16'd2);

        // Six bytes while a request is held: four fit, last two dropped
        ov_b[0] = 8'h11; ov_b[1] = 8'h22; ov_b[2] = 8'h33;
        ov_b[3] = 8'h44; ov_b[4] = 8'h55; ov_b[5] = 8'h66;
        send(8'hC3, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(ov_b[i], 1'b0, i < 4);
            if (i == 3) chk("ovf_ready_at_full", byte_ready, 1'b0);
        end
        chk("ovf_sticky", overflow_err, 1'b1);
        ack(10);
        wait_req(10, lat, ok);
        chk("ovf_word1_seen", ok, 1'b1);
        chk("ovf_word1_data", slave_data_to_sram, 16'h1122);
        ack(2);
        wait_req(10, lat, ok);
        chk("ovf_word2_seen", ok, 1'b1);
        ack(2);
        step(2);
        chk("ovf_words", words_written, 16'd5);
        chk("ovf_ready_drained", byte_ready, 1'b1);

        // SRAM FIFO full for 20 cycles during a request
        send(8'h3C, 1'b1, 1'b1);
        wait_req(10, lat, ok);
        chk("stall_req_seen", ok, 1'b1);
        fifo_i_full = 1'b1;
        step(20);
        chk("stall_stalled", stalled, 1'b1);
        chk("stall_write_held", slave_write, 1'b1);
        chk("stall_data", slave_data_to_sram, 16'h3C00);
        fifo_i_full = 1'b0;
        #1;
        chk("stall_released", stalled, 1'b0);
        ack(1);
        step(2);
        chk("stall_words", words_written, 16'd6);

        // Lone high byte: flushed by timeout only when the feature is built in
`ifdef SLAVE_PACK_TIMEOUT_EN
        send(8'h7E, 1'b0, 1'b1);
        model_flush();
        wait_req(20, lat, ok);
        chk("tmo_req_seen", ok, 1'b1);
        chk("tmo_latency", lat, 9);
        chk("tmo_data", slave_data_to_sram, 16'h7E00);
        ack(1);
`else
        send(8'h7E, 1'b0, 1'b1);
        wait_req(40, lat, ok);
        chk("no_tmo_req", ok, 1'b0);
        send(8'h7F, 1'b1, 1'b1);
        wait_req(10, lat, ok);
        chk("half_pair_seen", ok, 1'b1);
        chk("half_pair_data", slave_data_to_sram, 16'h7E7F);
        ack(1);
`endif
        step(2);
        chk("tmo_words", words_written, 16'd7);

        // Reset in the middle of a request, hint arrives after release
        send(8'h9D, 1'b1, 1'b1);
        wait_req(10, lat, ok);
        chk("rstreq_seen", ok, 1'b1);
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_write", slave_write, 1'b0);
        chk("midrst_data", slave_data_to_sram, 16'h0000);
        chk("midrst_words", words_written, 16'h0000);
        chk("midrst_overflow", overflow_err, 1'b0);
        chk("midrst_ready", byte_ready, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(3);
        model_reset();
        chk_en = 1'b1;
        slave_hint = 1'b1;
        step(1);
        slave_hint = 1'b0;
        step(20);
        chk("postrst_no_req", slave_write, 1'b0);
        chk("postrst_words", words_written, 16'h0000);

        // Normal operation resumes after reset
        send(8'hE1, 1'b0, 1'b1);
        send(8'hE2, 1'b1, 1'b1);
        wait_req(10, lat, ok);
        chk("postrst_req_seen", ok, 1'b1);
        chk("postrst_data", slave_data_to_sram, 16'hE1E2);
        ack(1);
        step(2);
        chk("postrst_words_1", words_written, 16'd1);
        chk("model_drained", exp_q.size(), 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
